// File: rtl/sha256_mem_host.sv
// Word RAM and host front end for simplified_sha256: loads a message from a valid/ready
// stream, starts the core, waits for done, then streams the 8-word digest back out.
module sha256_mem_host #(
    parameter int NUM_OF_WORDS = 40,
    parameter int MEM_DEPTH    = 2048,
    parameter int MSG_ADDR     = 0,
    parameter int OUT_ADDR     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        core_start,
    output logic [15:0] core_message_addr,
    output logic [15:0] core_output_addr,
    input  logic        core_done,
    input  logic        core_mem_we,
    input  logic [15:0] core_mem_addr,
    input  logic [31:0] core_mem_write_data,
    output logic [31:0] core_mem_read_data
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_FETCH, S_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] mem_q [MEM_DEPTH];

    logic          host_wr;
    logic          core_in_range;
    logic          core_wr;
    logic [AW-1:0] host_wr_idx;
    logic [AW-1:0] host_rd_idx;
    logic [AW-1:0] core_idx;

    assign core_message_addr = 16'(MSG_ADDR);
    assign core_output_addr  = 16'(OUT_ADDR);

    // A host load write and a core write never both land: the host wins the cycle.
    assign host_wr       = (state_q == S_LOAD) && in_valid && in_ready_q;
    assign host_wr_idx   = AW'(32'(cnt_q) + MSG_ADDR);
    assign host_rd_idx   = AW'(32'(cnt_q) + OUT_ADDR);
    assign core_in_range = ({16'b0, core_mem_addr} < 32'(MEM_DEPTH));
    assign core_idx      = AW'(core_mem_addr);
    assign core_wr       = core_mem_we && core_in_range && !host_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            out_data_q <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            out_data_q <= out_data_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && host_wr) mem_q[host_wr_idx] <= in_data;
        if (!reset && core_wr) mem_q[core_idx]    <= core_mem_write_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOAD: begin
                if (host_wr) begin
                    if (cnt_q == 16'(NUM_OF_WORDS - 1)) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_START:   state_d = S_WAIT_LO;
            // Wait for done to drop first so a done left high by the last job is not taken.
            S_WAIT_LO: if (!core_done) state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (core_done) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH:   state_d = S_SEND;
            S_SEND: begin
                if (out_ready) begin
                    if (cnt_q == 16'd7) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
            default:   state_d = S_LOAD;
        endcase
        in_ready_d = (state_d == S_LOAD);
    end

    always_comb begin
        out_data_d = out_data_q;
        if (state_q == S_FETCH) out_data_d = mem_q[host_rd_idx];
        rd_d = rd_q;
        if (!core_mem_we) rd_d = core_in_range ? mem_q[core_idx] : 32'h0;
    end

    always_comb begin
        in_ready           = in_ready_q;
        out_valid          = (state_q == S_SEND);
        out_last           = (state_q == S_SEND) && (cnt_q == 16'd7);
        out_data           = out_data_q;
        busy               = (state_q != S_LOAD);
        core_start         = (state_q == S_START);
        core_mem_read_data = rd_q;
    end
endmodule
